// File: rtl/word_scatter_16.sv
// word_scatter_16: serial-to-parallel distributor.
// Words arrive one at a time over a valid/ready handshake and are written in
// order into 16 lane registers. A frame ends after 16 words or on in_last.
// The finished frame is held on all lanes with out_valid until out_ack.
// Lanes are not cleared between frames. Consumers must use out_mask to tell
// which lanes hold fresh data.

module word_scatter_16 #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,

    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,

    output logic             out_valid,
    input  logic             out_ack,
    output logic [4:0]       out_count,
    output logic [15:0]      out_mask,

    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic [WIDTH-1:0] out5,
    output logic [WIDTH-1:0] out6,
    output logic [WIDTH-1:0] out7,
    output logic [WIDTH-1:0] out8,
    output logic [WIDTH-1:0] out9,
    output logic [WIDTH-1:0] out10,
    output logic [WIDTH-1:0] out11,
    output logic [WIDTH-1:0] out12,
    output logic [WIDTH-1:0] out13,
    output logic [WIDTH-1:0] out14,
    output logic [WIDTH-1:0] out15
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam int LANES = 16;

    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [4:0]       count_q, count_d;
    logic [15:0]      mask_q, mask_d;
    logic [WIDTH-1:0] lane_q [LANES];
    logic [WIDTH-1:0] lane_d [LANES];

    // A word is taken only while filling; in FULL the input side is closed.
    logic accept;
    assign accept = in_valid && (state_q == FILL);

    // Frame bookkeeping: write index, mask, count and FILL/FULL transitions.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;
        mask_d  = mask_q;
        unique case (state_q)
            FILL: begin
                if (in_valid) begin
                    mask_d = mask_q | (16'd1 << idx_q);
                    // Leaving index 15 always closes the frame, so idx never wraps.
                    if ((idx_q == 4'd15) || in_last) begin
                        state_d = FULL;
                        count_d = {1'b0, idx_q} + 5'd1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            FULL: begin
                // The ack edge only reopens the input; the word offered in
                // this same cycle is not taken.
                if (out_ack) begin
                    state_d = FILL;
                    idx_d   = 4'd0;
                    count_d = 5'd0;
                    mask_d  = 16'd0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Each lane loads the incoming word only when the write index points at it.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_d[gi] = (accept && (idx_q == 4'(gi))) ? in_data : lane_q[gi];
        end
    endgenerate

    // Control registers; reset drops any partial frame immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FILL;
            idx_q   <= 4'd0;
            count_q <= 5'd0;
            mask_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            mask_q  <= mask_d;
        end
    end

    // Lane registers; contents persist across frames until overwritten.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LANES; i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                lane_q[i] <= lane_d[i];
            end
        end
    end

    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == FULL);
    assign out_count = count_q;
    assign out_mask  = mask_q;

    assign out0  = lane_q[0];
    assign out1  = lane_q[1];
    assign out2  = lane_q[2];
    assign out3  = lane_q[3];
    assign out4  = lane_q[4];
    assign out5  = lane_q[5];
    assign out6  = lane_q[6];
    assign out7  = lane_q[7];
    assign out8  = lane_q[8];
    assign out9  = lane_q[9];
    assign out10 = lane_q[10];
    assign out11 = lane_q[11];
    assign out12 = lane_q[12];
    assign out13 = lane_q[13];
    assign out14 = lane_q[14];
    assign out15 = lane_q[15];

endmodule

// File: tb/tb_word_scatter_16.sv
// Testbench for word_scatter_16: directed frames, scoreboard checked by a
// separate monitor that compares each presented frame against the queue.

module tb_word_scatter_16;

    logic        clock;
    logic        reset_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic        out_valid;
    logic        out_ack;
    logic [4:0]  out_count;
    logic [15:0] out_mask;
    logic [31:0] out0, out1, out2, out3, out4, out5, out6, out7;
    logic [31:0] out8, out9, out10, out11, out12, out13, out14, out15;

    logic [31:0] dut_lane [16];

    typedef struct packed {
        logic [4:0]        count;
        logic [15:0]       mask;
        logic [15:0][31:0] lanes;
    } frame_t;

    frame_t sb_q [$];

    logic [15:0][31:0] exp_lanes;
    logic [15:0]       exp_mask;
    int                exp_idx;

    int tests_run = 0;
    int tests_failed = 0;

    word_scatter_16 #(.WIDTH(32)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .out_count (out_count),
        .out_mask  (out_mask),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out4      (out4),
        .out5      (out5),
        .out6      (out6),
        .out7      (out7),
        .out8      (out8),
        .out9      (out9),
        .out10     (out10),
        .out11     (out11),
        .out12     (out12),
        .out13     (out13),
        .out14     (out14),
        .out15     (out15)
    );

    assign dut_lane[0]  = out0;
    assign dut_lane[1]  = out1;
    assign dut_lane[2]  = out2;
    assign dut_lane[3]  = out3;
    assign dut_lane[4]  = out4;
    assign dut_lane[5]  = out5;
    assign dut_lane[6]  = out6;
    assign dut_lane[7]  = out7;
    assign dut_lane[8]  = out8;
    assign dut_lane[9]  = out9;
    assign dut_lane[10] = out10;
    assign dut_lane[11] = out11;
    assign dut_lane[12] = out12;
    assign dut_lane[13] = out13;
    assign dut_lane[14] = out14;
    assign dut_lane[15] = out15;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic model_clear(input logic lanes_too);
        exp_idx  = 0;
        exp_mask = 16'd0;
        if (lanes_too) exp_lanes = '0;
    endtask

    // Offer one word, wait (bounded) for acceptance, update the model.
    task automatic send(input logic [31:0] d, input logic last);
        int n;
        frame_t f;
        n = 0;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("send_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        exp_lanes[exp_idx] = d;
        exp_mask[exp_idx]  = 1'b1;
        if (exp_idx == 15 || last) begin
            f.count = 5'(exp_idx + 1);
            f.mask  = exp_mask;
            f.lanes = exp_lanes;
            sb_q.push_back(f);
            chk("valid_latency", {31'd0, out_valid}, 32'd1);
        end else begin
            exp_idx++;
            chk("no_early_valid", {31'd0, out_valid}, 32'd0);
        end
    endtask

    // Wait (bounded) for a frame, acknowledge it with in_valid low.
    task automatic ack();
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("ack_wait_valid", {31'd0, out_valid}, 32'd1);
        out_ack = 1'b1;
        @(posedge clock);
        #1;
        out_ack = 1'b0;
        model_clear(1'b0);
        chk("ack_valid_low", {31'd0, out_valid}, 32'd0);
        chk("ack_ready_high", {31'd0, in_ready}, 32'd1);
        chk("ack_mask_clear", {16'd0, out_mask}, 32'd0);
        chk("ack_count_clear", {27'd0, out_count}, 32'd0);
    endtask

    // Monitor: compare each newly presented frame against the scoreboard.
    logic shown = 1'b0;
    always @(negedge clock) begin
        frame_t f;
        if (!reset_n || !out_valid) begin
            shown = 1'b0;
        end else if (!shown) begin
            shown = 1'b1;
            if (sb_q.size() == 0) begin
                chk("unexpected_frame", 32'd1, 32'd0);
            end else begin
                f = sb_q.pop_front();
                chk("frame_count", {27'd0, out_count}, {27'd0, f.count});
                chk("frame_mask", {16'd0, out_mask}, {16'd0, f.mask});
                for (int li = 0; li < 16; li++) begin
                    chk($sformatf("frame_lane%0d", li), dut_lane[li], f.lanes[li]);
                end
                $display("[TB] frame count=%0d mask=%04h out0=%08h", out_count, out_mask, out0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n  = 1'b0;
        in_data  = 32'd0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        out_ack  = 1'b0;
        model_clear(1'b1);

        // Reset state
        #12;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mask", {16'd0, out_mask}, 32'd0);
        chk("rst_count", {27'd0, out_count}, 32'd0);
        chk("rst_out0", out0, 32'd0);
        reset_n = 1'b1;
        #1;
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clock);
        #1;

        // Short frame of three, then a single-word frame
        send(32'hA, 1'b0);
        send(32'hB, 1'b0);
        send(32'hC, 1'b1);
        chk("short_count", {27'd0, out_count}, 32'd3);
        chk("short_mask", {16'd0, out_mask}, 32'h0007);
        chk("short_out2", out2, 32'hC);
        chk("short_out3", out3, 32'h0);
        ack();
        send(32'hD, 1'b1);
        chk("single_count", {27'd0, out_count}, 32'd1);
        chk("single_mask", {16'd0, out_mask}, 32'h0001);
        chk("single_out0", out0, 32'hD);
        chk("single_out1_stale", out1, 32'hB);
        ack();

        // Full 16-word frame, streamed back-to-back
        for (int i = 0; i < 16; i++) send(32'h100 + 32'(i), 1'b0);
        chk("full_out0", out0, 32'h100);
        chk("full_out15", out15, 32'h10F);
        chk("full_count", {27'd0, out_count}, 32'd16);
        chk("full_mask", {16'd0, out_mask}, 32'hFFFF);
        chk("full_ready_low", {31'd0, in_ready}, 32'd0);

        // Back-pressure: 0xDEAD offered through FULL and the ack cycle
        in_data  = 32'hDEAD;
        in_valid = 1'b1;
        cycles(5);
        chk("bp_out0_held", out0, 32'h100);
        chk("bp_out15_held", out15, 32'h10F);
        chk("bp_ready_low", {31'd0, in_ready}, 32'd0);
        out_ack = 1'b1;
        @(posedge clock);
        #1;
        out_ack = 1'b0;
        model_clear(1'b0);
        chk("bp_ready_after_ack", {31'd0, in_ready}, 32'd1);
        chk("bp_not_taken_mask", {16'd0, out_mask}, 32'd0);
        chk("bp_not_taken_out0", out0, 32'h100);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        exp_lanes[0] = 32'hDEAD;
        exp_mask     = 16'h0001;
        exp_idx      = 1;
        chk("bp_taken_out0", out0, 32'hDEAD);
        chk("bp_taken_mask", {16'd0, out_mask}, 32'h0001);
        send(32'hE, 1'b1);
        chk("bp_frame_count", {27'd0, out_count}, 32'd2);
        ack();

        // Bubbles and a stray ack while filling
        send(32'h60, 1'b0);
        cycles(2);
        out_ack = 1'b1;
        cycles(1);
        out_ack = 1'b0;
        chk("stray_ack_ready", {31'd0, in_ready}, 32'd1);
        chk("stray_ack_valid", {31'd0, out_valid}, 32'd0);
        chk("stray_ack_mask", {16'd0, out_mask}, 32'h0001);
        send(32'h61, 1'b0);
        cycles(1);
        send(32'h62, 1'b1);
        chk("gap_count", {27'd0, out_count}, 32'd3);
        chk("gap_mask", {16'd0, out_mask}, 32'h0007);
        ack();

        // in_last without in_valid is ignored
        send(32'h50, 1'b0);
        in_last = 1'b1;
        cycles(3);
        in_last = 1'b0;
        chk("ign_last_mask", {16'd0, out_mask}, 32'h0001);
        chk("ign_last_valid", {31'd0, out_valid}, 32'd0);
        send(32'h51, 1'b1);
        chk("ign_count", {27'd0, out_count}, 32'd2);
        ack();

        // Asynchronous reset mid-frame after 7 words
        for (int i = 0; i < 7; i++) send(32'h300 + 32'(i), 1'b0);
        chk("pre_rst_mask", {16'd0, out_mask}, 32'h007F);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_mask", {16'd0, out_mask}, 32'd0);
        chk("async_rst_count", {27'd0, out_count}, 32'd0);
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_out0", out0, 32'd0);
        model_clear(1'b1);
        #2;
        reset_n = 1'b1;
        #1;
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 16; i++) send(32'h200 + 32'(i), 1'b0);
        chk("refill_out0", out0, 32'h200);
        chk("refill_out7", out7, 32'h207);
        ack();

        // Let the monitor drain the scoreboard
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
